imem_loader: RTL and testbench

Boot-time program loader: the write side of the instruction memory the single-cycle core fetches from. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes those words to consecutive word addresses from 0 and holds the core in reset until the image is complete. It sits between the host link (UART receiver or bench) and the instruction memory write port, and drives the core's reset.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_word_packer.sv | 40 ++++
 rtl/imem_loader.sv | 174 +++++++++++++++++
 tb/tb_imem_loader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int c_word_w            = 32;
    localparam int c_default_max_words = 1024;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : imem_word_packer
// Description : Collects four stream bytes, MSB first, into one 32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_byte_valid,
    input  logic [7:0]          i_byte,
    output logic                o_word_valid,
    output logic [c_word_w-1:0] o_word
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= 24'd0;
            r_cnt   <= 2'd0;
        end else if (i_clear) begin
            r_shift <= 24'd0;
            r_cnt   <= 2'd0;
        end else if (i_byte_valid) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    // The fourth byte completes the word in the same cycle it is offered.
    assign o_word_valid = i_byte_valid && (r_cnt == 2'd3);
    assign o_word       = {r_shift, i_byte};

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot loader; streams a length-prefixed image into instruction
//               memory and holds the core in reset until it is complete.
//               Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int MAX_WORDS = c_default_max_words
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [c_word_w-1:0] wr_data,
    output logic                cpu_hold,
    output logic                done,
    output logic                error
);

    localparam int c_cnt_w = (ADDR_W > 16) ? ADDR_W : 16;

    if (MAX_WORDS > (1 << ADDR_W)) begin : g_cfg_check
        $error("imem_loader: MAX_WORDS exceeds the ADDR_W address space");
    end

    state_t               r_state;
    logic [7:0]           r_len_hi;
    logic [c_cnt_w-1:0]   r_word_cnt;
    logic [c_cnt_w-1:0]   r_last_idx;

    logic                 w_fire;
    logic [15:0]          w_len;
    logic                 w_len_big;
    logic                 w_rearm;
    logic                 w_pack_byte;
    logic                 w_word_valid;
    logic [c_word_w-1:0]  w_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]           r_csum;
    logic [7:0]           w_csum_next;
    assign w_csum_next = r_csum + in_data;
`endif

    assign in_ready    = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                         (r_state == DATA)   || (r_state == CSUM);
    assign w_fire      = in_valid && in_ready;
    assign w_len       = {r_len_hi, in_data};
    assign w_len_big   = {16'd0, w_len} > 32'(MAX_WORDS);
    assign w_rearm     = start && ((r_state == DONE) || (r_state == ERR));
    assign w_pack_byte = w_fire && (r_state == DATA);

    imem_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_rearm),
        .i_byte_valid (w_pack_byte),
        .i_byte       (in_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= LEN_HI;
            r_len_hi   <= 8'd0;
            r_word_cnt <= '0;
            r_last_idx <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
        end else begin
            wr_en <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (w_fire) begin
                r_csum <= w_csum_next;
            end
`endif
            case (r_state)
                LEN_HI: begin
                    if (w_fire) begin
                        r_len_hi <= in_data;
                        r_state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (w_fire) begin
                        r_last_idx <= c_cnt_w'(w_len - 16'd1);
                        if (w_len_big) begin
                            r_state <= ERR;
                            error   <= 1'b1;
                        end else if (w_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state  <= CSUM;
`else
                            r_state  <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_word_valid) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= r_word_cnt[ADDR_W-1:0];
                        wr_data    <= w_word;
                        r_word_cnt <= r_word_cnt + c_cnt_w'(1);
                        if (r_word_cnt == r_last_idx) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state  <= CSUM;
`else
                            r_state  <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (w_fire) begin
                        if (w_csum_next == 8'h00) begin
                            r_state  <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            r_state <= ERR;
                            error   <= 1'b1;
                        end
                    end
                end
`endif
                DONE, ERR: begin
                    // Re-arming clears all progress and re-asserts core reset at once.
                    if (start) begin
                        r_state    <= LEN_HI;
                        r_word_cnt <= '0;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= 8'd0;
`endif
                    end
                end
                default: begin
                    r_state <= ERR;
                    error   <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader (table, directed, random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int MAXW = 1024;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  b [12];
        int          nb;
        bit          exp_err;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    wr_t        exp_w[$];
    wr_t        got_w[$];
    logic [7:0] stim_q[$];
    vec_t       tbl[4];

    imem_loader #(.ADDR_W(16), .MAX_WORDS(MAXW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && wr_en) got_w.push_back('{addr: wr_addr, data: wr_data});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle(input int k);
        in_valid = 1'b0;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        chk("ready_on_push", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic rearm();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("rearm_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rearm_done",     {31'd0, done},     32'd0);
        chk("rearm_error",    {31'd0, error},    32'd0);
        chk("rearm_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic append_csum(input bit corrupt);
        logic [7:0] s;
        s = 8'd0;
        foreach (stim_q[i]) s = s + stim_q[i];
        s = 8'd0 - s;
        if (corrupt) s = s ^ 8'(1 << $urandom_range(0, 7));
        if (CS) stim_q.push_back(s);
    endtask

    // Reference: image semantics derived from the stream rules, not from the RTL.
    task automatic run_stream(input int gap_mode, input string tag);
        int         n;
        int         consumed;
        int         idx;
        bit         exp_err;
        logic [7:0] sum;
        exp_w.delete();
        got_w.delete();
        n = int'({stim_q[0], stim_q[1]});
        if (n > MAXW) begin
            exp_err  = 1'b1;
            consumed = 2;
        end else begin
            for (int w = 0; w < n; w++)
                exp_w.push_back('{addr: 16'(w),
                                  data: {stim_q[2+4*w], stim_q[3+4*w], stim_q[4+4*w], stim_q[5+4*w]}});
            consumed = 2 + 4 * n + (CS ? 1 : 0);
            sum = 8'd0;
            for (int i = 0; i < consumed; i++) sum = sum + stim_q[i];
            exp_err = CS && (sum != 8'h00);
        end
        for (int i = 0; i < consumed; i++) begin
            if (i > 0) begin
                case (gap_mode)
                    1: idle(1);
                    2: idle($urandom_range(0, 3));
                    3: if (i == 4) begin
                           start = 1'b1;
                           idle(1);
                           start = 1'b0;
                       end
                    default: ;
                endcase
            end
            if (i == consumed - 1) begin
                chk({tag, "_done_early"},  {31'd0, done},  32'd0);
                chk({tag, "_error_early"}, {31'd0, error}, 32'd0);
            end
            push(stim_q[i]);
            if (n <= MAXW && i >= 2 && i < 2 + 4 * n) begin
                idx = i - 2;
                if (idx % 4 == 3) begin
                    chk({tag, "_wr_en"},   {31'd0, wr_en}, 32'd1);
                    chk({tag, "_wr_addr"}, {16'd0, wr_addr}, 32'(idx / 4));
                    chk({tag, "_wr_data"}, wr_data, exp_w[idx/4].data);
                end else begin
                    chk({tag, "_wr_en_idle"}, {31'd0, wr_en}, 32'd0);
                end
            end
        end
        chk({tag, "_done"},     {31'd0, done},     {31'd0, !exp_err});
        chk({tag, "_error"},    {31'd0, error},    {31'd0, exp_err});
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, exp_err});
        chk({tag, "_ready_end"},{31'd0, in_ready}, 32'd0);
        idle(2);
        chk({tag, "_nwrites"}, 32'(got_w.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            chk({tag, "_log_addr"}, {16'd0, got_w[i].addr}, {16'd0, exp_w[i].addr});
            chk({tag, "_log_data"}, got_w[i].data, exp_w[i].data);
        end
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;

        if (CS) begin
            tbl[0] = '{b: '{8'h00,8'h02,8'h20,8'h08,8'h00,8'h05,8'h20,8'h09,8'h00,8'h07,8'hA1,8'h00},
                       nb: 11, exp_err: 1'b0, nw: 2, w0: 32'h20080005, w1: 32'h20090007};
            tbl[1] = '{b: '{8'h00,8'h01,8'hAA,8'hBB,8'hCC,8'hDD,8'hF1,8'h00,8'h00,8'h00,8'h00,8'h00},
                       nb: 7, exp_err: 1'b0, nw: 1, w0: 32'hAABBCCDD, w1: 32'h0};
            tbl[2] = '{b: '{8'h00,8'h01,8'hAA,8'hBB,8'hCC,8'hDD,8'hF2,8'h00,8'h00,8'h00,8'h00,8'h00},
                       nb: 7, exp_err: 1'b1, nw: 1, w0: 32'hAABBCCDD, w1: 32'h0};
        end else begin
            tbl[0] = '{b: '{8'h00,8'h02,8'h20,8'h08,8'h00,8'h05,8'h20,8'h09,8'h00,8'h07,8'h00,8'h00},
                       nb: 10, exp_err: 1'b0, nw: 2, w0: 32'h20080005, w1: 32'h20090007};
            tbl[1] = '{b: '{8'h00,8'h01,8'hAA,8'hBB,8'hCC,8'hDD,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                       nb: 6, exp_err: 1'b0, nw: 1, w0: 32'hAABBCCDD, w1: 32'h0};
            tbl[2] = '{b: '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                       nb: 2, exp_err: 1'b0, nw: 0, w0: 32'h0, w1: 32'h0};
        end
        tbl[3] = '{b: '{8'h04,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                   nb: 2, exp_err: 1'b1, nw: 0, w0: 32'h0, w1: 32'h0};

        // Reset state (held over several edges so the async branch is exercised).
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_wr_en",    {31'd0, wr_en},    32'd0);
        chk("rst_wr_addr",  {16'd0, wr_addr},  32'd0);
        chk("rst_wr_data",  wr_data,           32'd0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_done",     {31'd0, done},     32'd0);
        chk("rst_error",    {31'd0, error},    32'd0);
        rst = 1'b1;
        idle(2);

        for (int v = 0; v < 4; v++) begin
            stim_q.delete();
            for (int i = 0; i < tbl[v].nb; i++) stim_q.push_back(tbl[v].b[i]);
            run_stream(0, $sformatf("tbl%0d", v));
            chk("tbl_error",   {31'd0, error}, {31'd0, tbl[v].exp_err});
            chk("tbl_nwrites", 32'(got_w.size()), 32'(tbl[v].nw));
            if (tbl[v].nw > 0 && got_w.size() > 0) chk("tbl_w0", got_w[0].data, tbl[v].w0);
            if (tbl[v].nw > 1 && got_w.size() > 1) chk("tbl_w1", got_w[1].data, tbl[v].w1);
            rearm();
        end

        // in_valid toggling every cycle through a one-word load.
        stim_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        append_csum(1'b0);
        run_stream(1, "toggle");
        rearm();

        // start pulsed mid-load must be ignored.
        stim_q = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5, 8'hE6, 8'hD7, 8'hC8};
        append_csum(1'b0);
        run_stream(3, "start_ignored");
        rearm();

        // Asynchronous reset after six data bytes of a two-word load.
        push(8'h00);
        push(8'h02);
        for (int i = 0; i < 6; i++) push(8'h11 + 8'(i));
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_wr_en",    {31'd0, wr_en},    32'd0);
        chk("midrst_wr_addr",  {16'd0, wr_addr},  32'd0);
        chk("midrst_wr_data",  wr_data,           32'd0);
        chk("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("midrst_done",     {31'd0, done},     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        stim_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        append_csum(1'b0);
        run_stream(0, "post_reset");

        // From DONE: start, then an empty image.
        chk("pre_start_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        rearm();
        stim_q = '{8'h00, 8'h00};
        append_csum(1'b0);
        run_stream(0, "empty");
        rearm();

        // Length boundaries around MAX_WORDS.
        stim_q = '{8'h04, 8'h00};
        for (int i = 0; i < 4 * MAXW; i++) stim_q.push_back(8'($urandom));
        append_csum(1'b0);
        run_stream(0, "max_words");
        rearm();
        stim_q = '{8'h04, 8'h01};
        run_stream(2, "max_plus1");
        rearm();

        for (int r = 0; r < 20; r++) begin
            int n;
            stim_q.delete();
            if ($urandom_range(0, 9) == 0) n = $urandom_range(MAXW + 1, 65535);
            else n = $urandom_range(0, 5);
            stim_q.push_back(8'(n >> 8));
            stim_q.push_back(8'(n));
            if (n <= MAXW) begin
                for (int i = 0; i < 4 * n; i++) stim_q.push_back(8'($urandom));
                append_csum($urandom_range(0, 3) == 0);
            end
            run_stream(2, $sformatf("rand%0d", r));
            rearm();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
